// File: rtl/pong_pkg.sv
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared state encoding, screen/ball/paddle geometry and the
//            centre positions used by the Pong game sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pong_pkg;

  // Game sequencer states; the encoding is visible on oState.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Screen and object geometry.
  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int BALL_SIZE    = 8;
  localparam int PADDLE_H     = 64;
  localparam int PADDLE_W     = 8;
  localparam int PADDLE_L_X   = 16;
  localparam int PADDLE_R_X   = 616;
  localparam int PADDLE_SPEED = 4;
  localparam int BALL_SPEED   = 2;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE    = 7;

  // Datapath widths. Ball arithmetic uses one extra bit so x+step never wraps.
  localparam int POS_W   = 10;
  localparam int CALC_W  = 11;
  localparam int SCORE_W = 4;
  localparam int CNT_W   = $clog2(SERVE_FRAMES + 1);

  // Centre / reset positions.
  localparam logic [POS_W-1:0] BALL_X0      = POS_W'((H_ACTIVE - BALL_SIZE) / 2);  // 316
  localparam logic [POS_W-1:0] BALL_Y0      = POS_W'((V_ACTIVE - BALL_SIZE) / 2);  // 236
  localparam logic [POS_W-1:0] PADDLE_Y0    = POS_W'((V_ACTIVE - PADDLE_H) / 2);   // 208
  localparam logic [POS_W-1:0] PADDLE_Y_MAX = POS_W'(V_ACTIVE - PADDLE_H);         // 416
  localparam logic [POS_W-1:0] PADDLE_STEP  = POS_W'(PADDLE_SPEED);

  // Ball collision constants in the widened arithmetic domain.
  localparam logic [CALC_W-1:0] BALL_STEP_C = CALC_W'(BALL_SPEED);
  localparam logic [CALC_W-1:0] BALL_SIZE_C = CALC_W'(BALL_SIZE);
  localparam logic [CALC_W-1:0] PADDLE_H_C  = CALC_W'(PADDLE_H);
  localparam logic [CALC_W-1:0] X_MAX_C     = CALC_W'(H_ACTIVE - BALL_SIZE);     // 632
  localparam logic [CALC_W-1:0] Y_MAX_C     = CALC_W'(V_ACTIVE - BALL_SIZE);     // 472
  localparam logic [CALC_W-1:0] L_HIT_X_C   = CALC_W'(PADDLE_L_X + PADDLE_W);    // 24
  localparam logic [CALC_W-1:0] R_EDGE_C    = CALC_W'(PADDLE_R_X);               // 616
  localparam logic [CALC_W-1:0] R_HIT_X_C   = CALC_W'(PADDLE_R_X - BALL_SIZE);   // 608

  localparam logic [CNT_W-1:0]   SERVE_LOAD  = CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] WIN_SCORE_C = SCORE_W'(WIN_SCORE);

  // Score increment that sticks at the top of the score range.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_game_ctrl_paddle.sv
// ============================================================================
// Module   : pong_paddle
// Purpose  : One paddle register with a saturating up/down mover that steps
//            once per enabled frame tick.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pong_paddle
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_up,
  input  logic             i_dn,
  input  logic             i_recentre,
  output logic [POS_W-1:0] o_y
);

  logic [POS_W-1:0] y_q, y_d;

  // Next paddle position: recentre wins, otherwise one saturating step per tick.
  always_comb begin
    y_d = y_q;
    if (i_recentre) begin
      y_d = PADDLE_Y0;
    end else if (i_tick && i_up && !i_dn) begin
      y_d = (y_q < PADDLE_STEP) ? '0 : y_q - PADDLE_STEP;
    end else if (i_tick && i_dn && !i_up) begin
      y_d = (y_q > PADDLE_Y_MAX - PADDLE_STEP) ? PADDLE_Y_MAX : y_q + PADDLE_STEP;
    end
  end

  // Paddle position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= PADDLE_Y0;
    else        y_q <= y_d;
  end

  assign o_y = y_q;

endmodule

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// ============================================================================
// Module   : pong_game_ctrl
// Purpose  : Frame-rate Pong sequencer. Advances ball, paddles and scores once
//            per frame on the falling edge of vertical sync and runs the
//            idle/serve/play/point/over state machine.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               iVS,
  input  logic               iStart,
  input  logic               iL_up,
  input  logic               iL_dn,
  input  logic               iR_up,
  input  logic               iR_dn,
  output logic [POS_W-1:0]   ball_x,
  output logic [POS_W-1:0]   ball_y,
  output logic [POS_W-1:0]   paddleL_y,
  output logic [POS_W-1:0]   paddleR_y,
  output logic [SCORE_W-1:0] scoreL,
  output logic [SCORE_W-1:0] scoreR,
  output logic [2:0]         oState,
  output logic               game_over
);

  state_e               state_q, state_d;
  logic [POS_W-1:0]     bx_q, bx_d, by_q, by_d;
  logic                 dx_q, dx_d;          // 1 = moving right
  logic                 dy_q, dy_d;          // 1 = moving down
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d, score_r_q, score_r_d;
  logic                 game_over_q, game_over_d;
  logic                 vs_q, start_q;

  logic                 w_tick, w_start_edge, w_pad_tick, w_recentre;
  logic [POS_W-1:0]     w_pad_l_y, w_pad_r_y;
  logic [CALC_W-1:0]    w_x, w_y, w_nx, w_ny, w_pl, w_pr;
  logic                 w_ovl_l, w_ovl_r, w_hit_l, w_hit_r;
  logic                 w_miss_l, w_miss_r, w_top, w_bot;

  // Frame tick on the sampled 1->0 of iVS; serve button edge from one register.
  assign w_tick       = vs_q & ~iVS;
  assign w_start_edge = iStart & ~start_q;

  // Paddles only move while a rally is being served or played.
  assign w_pad_tick = w_tick && ((state_q == ST_SERVE) || (state_q == ST_PLAY));
  assign w_recentre = (state_q == ST_OVER) && w_start_edge;

  pong_paddle u_paddle_l (
    .clk        (iVGA_CLK),
    .rst_n      (iRST_n),
    .i_tick     (w_pad_tick),
    .i_up       (iL_up),
    .i_dn       (iL_dn),
    .i_recentre (w_recentre),
    .o_y        (w_pad_l_y)
  );

  pong_paddle u_paddle_r (
    .clk        (iVGA_CLK),
    .rst_n      (iRST_n),
    .i_tick     (w_pad_tick),
    .i_up       (iR_up),
    .i_dn       (iR_dn),
    .i_recentre (w_recentre),
    .o_y        (w_pad_r_y)
  );

  // Candidate ball move and collision tests against pre-update paddle positions.
  assign w_x  = {1'b0, bx_q};
  assign w_y  = {1'b0, by_q};
  assign w_pl = {1'b0, w_pad_l_y};
  assign w_pr = {1'b0, w_pad_r_y};
  assign w_nx = dx_q ? (w_x + BALL_STEP_C) : (w_x - BALL_STEP_C);
  assign w_ny = dy_q ? (w_y + BALL_STEP_C) : (w_y - BALL_STEP_C);

  assign w_ovl_l  = (w_y + BALL_SIZE_C > w_pl) && (w_y < w_pl + PADDLE_H_C);
  assign w_ovl_r  = (w_y + BALL_SIZE_C > w_pr) && (w_y < w_pr + PADDLE_H_C);
  assign w_hit_l  = !dx_q && (w_x >= L_HIT_X_C) && (w_nx <= L_HIT_X_C) && w_ovl_l;
  assign w_hit_r  = dx_q && (w_x + BALL_SIZE_C <= R_EDGE_C)
                    && (w_nx + BALL_SIZE_C >= R_EDGE_C) && w_ovl_r;
  assign w_miss_l = !dx_q && (w_x < BALL_STEP_C) && !w_hit_l;
  assign w_miss_r = dx_q && (w_x + BALL_STEP_C > X_MAX_C) && !w_hit_r;
  assign w_top    = !dy_q && (w_y < BALL_STEP_C);
  assign w_bot    = dy_q && (w_y + BALL_STEP_C > Y_MAX_C);

  // Game state machine: next state, ball, direction, serve counter and scores.
  always_comb begin
    state_d   = state_q;
    bx_d      = bx_q;
    by_d      = by_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;

    case (state_q)
      ST_IDLE: begin
        if (w_start_edge) begin
          state_d = ST_SERVE;
          cnt_d   = SERVE_LOAD;
        end
      end

      ST_SERVE: begin
        if (w_tick) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (w_tick) begin
          if (w_miss_l) begin
            score_r_d = sat_inc(score_r_q);
            dx_d      = 1'b0;
            state_d   = ST_POINT;
          end else if (w_miss_r) begin
            score_l_d = sat_inc(score_l_q);
            dx_d      = 1'b1;
            state_d   = ST_POINT;
          end else begin
            // Horizontal: paddle hits pin the ball to the paddle face.
            if (w_hit_l) begin
              bx_d = L_HIT_X_C[POS_W-1:0];
              dx_d = 1'b1;
            end else if (w_hit_r) begin
              bx_d = R_HIT_X_C[POS_W-1:0];
              dx_d = 1'b0;
            end else begin
              bx_d = w_nx[POS_W-1:0];
            end
            // Vertical: wall reflection is independent of paddle hits.
            if (w_top) begin
              by_d = '0;
              dy_d = 1'b1;
            end else if (w_bot) begin
              by_d = Y_MAX_C[POS_W-1:0];
              dy_d = 1'b0;
            end else begin
              by_d = w_ny[POS_W-1:0];
            end
          end
        end
      end

      ST_POINT: begin
        if (w_tick) begin
          if ((score_l_q >= WIN_SCORE_C) || (score_r_q >= WIN_SCORE_C)) begin
            state_d = ST_OVER;
          end else begin
            bx_d    = BALL_X0;
            by_d    = BALL_Y0;
            dy_d    = 1'b1;
            cnt_d   = SERVE_LOAD;
            state_d = ST_SERVE;
          end
        end
      end

      ST_OVER: begin
        if (w_start_edge) begin
          state_d   = ST_IDLE;
          score_l_d = '0;
          score_r_d = '0;
          bx_d      = BALL_X0;
          by_d      = BALL_Y0;
          dx_d      = 1'b1;
          dy_d      = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    game_over_d = (state_d == ST_OVER);
  end

  // State, ball, score and edge-detector registers.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= ST_IDLE;
      bx_q        <= BALL_X0;
      by_q        <= BALL_Y0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      cnt_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      game_over_q <= 1'b0;
      vs_q        <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
      vs_q        <= iVS;
      start_q     <= iStart;
    end
  end

  assign ball_x    = bx_q;
  assign ball_y    = by_q;
  assign paddleL_y = w_pad_l_y;
  assign paddleR_y = w_pad_r_y;
  assign scoreL    = score_l_q;
  assign scoreR    = score_r_q;
  assign oState    = state_q;
  assign game_over = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// ============================================================================
// Module   : tb_pong_game_ctrl
// Purpose  : Self-checking bench for pong_game_ctrl. Directed frames drive the
//            game; expected snapshots go into a queue that a monitor drains.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, vs, start, l_up, l_dn, r_up, r_dn;
  logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic [3:0] score_l, score_r;
  logic [2:0] state;
  logic       game_over;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .iVGA_CLK  (clk),
    .iRST_n    (rst_n),
    .iVS       (vs),
    .iStart    (start),
    .iL_up     (l_up),
    .iL_dn     (l_dn),
    .iR_up     (r_up),
    .iR_dn     (r_dn),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .paddleL_y (paddle_l_y),
    .paddleR_y (paddle_r_y),
    .scoreL    (score_l),
    .scoreR    (score_r),
    .oState    (state),
    .game_over (game_over)
  );

  // Mask bits selecting which fields an expectation checks.
  localparam logic [7:0] M_ST = 8'h01, M_BX = 8'h02, M_BY = 8'h04, M_PL = 8'h08;
  localparam logic [7:0] M_PR = 8'h10, M_SL = 8'h20, M_SR = 8'h40, M_GO = 8'h80;
  localparam logic [7:0] M_BALL = M_BX | M_BY;

  typedef struct {
    string      name;
    logic [7:0] mask;
    int         st, bx, by, pl, pr, sl, sr, go;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void cmp(string nm, string fld, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    end
  endfunction

  // Monitor: pops every pending expectation and compares on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.mask[0]) cmp(e.name, "state",     int'(state),      e.st);
        if (e.mask[1]) cmp(e.name, "ball_x",    int'(ball_x),     e.bx);
        if (e.mask[2]) cmp(e.name, "ball_y",    int'(ball_y),     e.by);
        if (e.mask[3]) cmp(e.name, "paddleL_y", int'(paddle_l_y), e.pl);
        if (e.mask[4]) cmp(e.name, "paddleR_y", int'(paddle_r_y), e.pr);
        if (e.mask[5]) cmp(e.name, "scoreL",    int'(score_l),    e.sl);
        if (e.mask[6]) cmp(e.name, "scoreR",    int'(score_r),    e.sr);
        if (e.mask[7]) cmp(e.name, "game_over", int'(game_over),  e.go);
      end
    end
  end

  // Push one expectation and give the monitor one falling edge to consume it.
  task automatic expect_out(string nm, logic [7:0] m, int st, int bx, int by,
                            int pl, int pr, int sl, int sr, int go);
    exp_t e;
    e.name = nm; e.mask = m;
    e.st = st; e.bx = bx; e.by = by; e.pl = pl; e.pr = pr;
    e.sl = sl; e.sr = sr; e.go = go;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s monitor_drain actual=%0d required=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // One frame: iVS low for one cycle, optionally with the start button rising.
  task automatic do_tick(input bit with_start);
    @(posedge clk); #1;
    vs = 1'b0;
    if (with_start) start = 1'b1;
    @(posedge clk); #1;
    vs = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick(1'b0);
  endtask

  task automatic press_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    expect_out("reset", 8'hFF, 0, 316, 236, 208, 208, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vs = 1'b1; start = 1'b0;
    l_up = 1'b0; l_dn = 1'b0; r_up = 1'b0; r_dn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out("por", 8'hFF, 0, 316, 236, 208, 208, 0, 0, 0);

    // ---- Game A: serve with paddles driven to the rails, right hit, top wall, left hit
    press_start();
    expect_out("serve_entry", M_ST | M_BALL, 1, 316, 236, 0, 0, 0, 0, 0);
    l_up = 1'b1; r_dn = 1'b1;
    ticks(52);
    expect_out("pad_sat_52", M_ST | M_PL | M_PR, 1, 0, 0, 0, 416, 0, 0, 0);
    ticks(7);
    expect_out("serve_59", M_ST, 1, 0, 0, 0, 0, 0, 0, 0);
    ticks(1);
    expect_out("play_60", M_ST | M_BALL | M_PL | M_PR, 2, 316, 236, 0, 416, 0, 0, 0);
    l_up = 1'b0; r_dn = 1'b0;
    ticks(1);
    expect_out("first_move", M_BALL, 0, 318, 238, 0, 0, 0, 0, 0);
    ticks(145);
    expect_out("r_paddle_hit", M_ST | M_BALL, 2, 608, 418, 0, 0, 0, 0, 0);
    ticks(1);
    expect_out("after_r_hit", M_BALL, 0, 606, 416, 0, 0, 0, 0, 0);
    ticks(208);
    expect_out("top_reach", M_BALL, 0, 190, 0, 0, 0, 0, 0, 0);
    ticks(1);
    expect_out("top_bounce", M_BALL, 0, 188, 0, 0, 0, 0, 0, 0);
    ticks(1);
    expect_out("top_down", M_BALL, 0, 186, 2, 0, 0, 0, 0, 0);
    l_dn = 1'b1;
    ticks(35);
    l_dn = 1'b0;
    expect_out("pad_l_move", M_PL, 0, 0, 0, 140, 0, 0, 0, 0);
    ticks(45);
    expect_out("approach_l", M_BALL, 0, 26, 162, 0, 0, 0, 0, 0);
    ticks(1);
    expect_out("l_paddle_hit", M_BALL, 0, 24, 164, 0, 0, 0, 0, 0);
    ticks(1);
    expect_out("after_l_hit", M_ST | M_BALL, 2, 26, 166, 0, 0, 0, 0, 0);
    apply_reset();

    // ---- Game B: left miss, point, re-serve toward the left
    press_start();
    l_up = 1'b1; r_dn = 1'b1;
    ticks(60);
    l_up = 1'b0; r_dn = 1'b0;
    ticks(450);
    expect_out("at_left_edge", M_ST | M_BALL | M_SR, 2, 0, 188, 0, 0, 0, 0, 0);
    ticks(1);
    expect_out("miss_left", M_ST | M_SL | M_SR, 3, 0, 0, 0, 0, 0, 1, 0);
    ticks(1);
    expect_out("reserve", M_ST | M_BALL, 1, 316, 236, 0, 0, 0, 1, 0);
    ticks(59);
    expect_out("reserve_59", M_ST | M_BALL, 1, 316, 236, 0, 0, 0, 0, 0);
    ticks(1);
    expect_out("replay", M_ST | M_BALL, 2, 316, 236, 0, 0, 0, 0, 0);
    ticks(1);
    expect_out("serve_left", M_BALL, 0, 314, 238, 0, 0, 0, 0, 0);
    apply_reset();

    // ---- Game C: start with a coincident tick, right misses up to game over
    r_up = 1'b1; r_dn = 1'b1;
    do_tick(1'b1);
    start = 1'b0;
    expect_out("start_w_tick", M_ST, 1, 0, 0, 0, 0, 0, 0, 0);
    ticks(59);
    expect_out("serve_59_c", M_ST | M_PR, 1, 0, 0, 0, 208, 0, 0, 0);
    ticks(1);
    expect_out("play_c", M_ST | M_PR, 2, 0, 0, 0, 208, 0, 0, 0);
    r_up = 1'b0; r_dn = 1'b0;
    press_start();
    expect_out("start_in_play", M_ST, 2, 0, 0, 0, 0, 0, 0, 0);
    ticks(158);
    expect_out("at_right_edge", M_ST | M_BALL, 2, 632, 394, 0, 0, 0, 0, 0);
    ticks(1);
    expect_out("miss_right_1", M_ST | M_SL | M_SR, 3, 0, 0, 0, 0, 1, 0, 0);
    for (int p = 2; p <= 7; p++) begin
      ticks(220);
      expect_out("miss_right_n", M_ST | M_SL | M_SR, 3, 0, 0, 0, 0, p, 0, 0);
    end
    ticks(1);
    expect_out("game_over", M_ST | M_GO | M_SL, 4, 0, 0, 0, 0, 7, 0, 1);
    ticks(1);
    expect_out("over_frozen", M_ST | M_GO, 4, 0, 0, 0, 0, 0, 0, 1);
    press_start();
    expect_out("over_to_idle", 8'hFF, 0, 316, 236, 208, 208, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Frame-rate game sequencer for the Pong display.
- Owns the ball and paddle positions and the scores, and drives the ball_x/ball_y/paddleL_y/paddleR_y inputs of the VGA controller.
- Advances the game exactly once per video frame, triggered by the start of vertical sync.
- Runs the serve / play / point / game-over state machine, including wall and paddle collisions.

Parameters:
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in lines
- BALL_SIZE, 8, ball edge length in pixels
- PADDLE_H, 64, paddle height
- PADDLE_W, 8, paddle width
- PADDLE_L_X, 16, left paddle left edge
- PADDLE_R_X, 616, right paddle left edge
- PADDLE_SPEED, 4, paddle pixels per frame
- BALL_SPEED, 2, ball pixels per frame, each axis
- SERVE_FRAMES, 60, frames the ball is held before launch
- WIN_SCORE, 7, points needed to win

Ports:
- iVGA_CLK  in  1  pixel clock; the only clock
- iRST_n  in  1  reset, asynchronous, active-low
- iVS  in  1  vertical sync, active-low, same clock domain
- iStart  in  1  start/serve button, active-high level
- iL_up, iL_dn, iR_up, iR_dn  in  1 each  paddle buttons, active-high
- ball_x, ball_y  out  10 each  ball top-left corner
- paddleL_y, paddleR_y  out  10 each  paddle top edge
- scoreL, scoreR  out  4 each  scores
- oState  out  3  FSM state: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
- game_over  out  1  high while in OVER

Behaviour:
- All outputs are registered.
- Reset (asynchronous, active-low) takes effect immediately, including mid-frame. Reset values:
  - state IDLE
  - ball 316/236 (centred)
  - paddles 208
  - scores 0
  - dx=right, dy=down
  - serve counter 0
  - game_over 0
- tick: one-cycle pulse in the cycle after iVS is sampled 1 in the previous cycle and 0 now. Exactly one tick per frame.
- start_edge: iStart 0→1, detected with one register. Recognised only in IDLE and OVER; ignored in all other states.
- IDLE:
  - Ball centred, scores held at 0.
  - start_edge → SERVE, serve counter loaded with SERVE_FRAMES.
  - A tick in the same cycle as start_edge is not counted.
- SERVE:
  - Ball held centred; counter decrements on each tick.
  - A tick with counter=1 → PLAY. The ball first moves on the following tick.
- PLAY, on each tick:
  - Candidate position: nx = x±BALL_SPEED, ny = y±BALL_SPEED. All arithmetic is done in 11 bits so nothing wraps.
  - Top wall: dy=up and y<BALL_SPEED → ny=0, dy=down.
  - Bottom wall: dy=down and y+BALL_SPEED > V_ACTIVE−BALL_SIZE → ny=472, dy=up.
  - Left paddle: dx=left, x ≥ 24 (PADDLE_L_X+PADDLE_W), nx ≤ 24, and vertical overlap (y+BALL_SIZE > paddleL_y and y < paddleL_y+PADDLE_H) → nx=24, dx=right.
  - Right paddle: dx=right, x+BALL_SIZE ≤ 616, nx+BALL_SIZE ≥ 616, and overlap with paddleR_y → nx=608, dx=left.
  - Overlap tests use the paddle positions from before this tick's paddle update.
  - Miss left: dx=left, x<BALL_SPEED, no paddle hit → scoreR+1, serve dx=left, → POINT.
  - Miss right: dx=right, x+BALL_SPEED > H_ACTIVE−BALL_SIZE, no paddle hit → scoreL+1, serve dx=right, → POINT.
  - Priority: paddle hit over miss. Wall reflection is evaluated independently and applies on the same tick as a paddle hit.
  - Scores saturate at 15.
- POINT:
  - Ball frozen at its last position.
  - Next tick: if either score ≥ WIN_SCORE → OVER; otherwise ball recentred, dy=down, counter reloaded, → SERVE.
- OVER:
  - game_over=1; everything frozen.
  - start_edge → IDLE: scores cleared, ball and paddles recentred, dx=right.
- Paddles:
  - Update on tick in SERVE and PLAY only.
  - up: y−PADDLE_SPEED, saturating at 0.
  - dn: y+PADDLE_SPEED, saturating at V_ACTIVE−PADDLE_H (416).
  - up and dn together, or neither: hold.
  - Returned to 208 only by reset or OVER→IDLE.

Decomposition:
- Shared package pong_pkg holds:
  - the state encoding
  - the screen, ball and paddle geometry constants
  - the reset/centre positions (316, 236, 208)
- Sub-module pong_paddle holds one paddle register with the saturating up/down mover on tick. It is instantiated twice, for left and right.

Test Plan:
- Reset, start_edge, 60 ticks → oState=2 after tick 60; tick 61 → ball_x=318, ball_y=238.
- PLAY, ball y=1, dy=up, tick → ball_y=0, dy=down; next tick → ball_y=2.
- PLAY, paddleL_y=200, ball x=25, y=230, dx=left, tick → ball_x=24; next tick → ball_x=26.
- PLAY, paddleL_y=0, ball x=1, y=300, dx=left, tick → scoreR=1, oState=3; next tick → oState=1, ball 316/236; after serve the ball moves left.
- scoreL=6, right miss → scoreL=7, POINT; next tick → OVER, game_over=1; start_edge → IDLE, scores 0.
- iL_up held for 60 ticks in SERVE from 208 → 0 after 52 ticks, then stays 0; iR_up and iR_dn held together → paddleR_y stays 208; iRST_n low mid-PLAY → all reset values in the same cycle.
